// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, latencies and FSM state type for mult_div_sched.
// MDU_MADD_EN turns on decoding of the MADD/MADDU/MSUB/MSUBU codes.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } md_state_e;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;
   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
   localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

   // Unknown codes (and accumulate codes when the feature is off) fold to NONE.
   function automatic md_op_e decode_op(input logic [3:0] code);
      md_op_e op;
      case (code)
         4'd1:    op = OP_MULT;
         4'd2:    op = OP_MULTU;
         4'd3:    op = OP_DIV;
         4'd4:    op = OP_DIVU;
         4'd5:    op = OP_MFHI;
         4'd6:    op = OP_MFLO;
         4'd7:    op = OP_MTHI;
         4'd8:    op = OP_MTLO;
`ifdef MDU_MADD_EN
         4'd9:    op = OP_MADD;
         4'd10:   op = OP_MADDU;
         4'd11:   op = OP_MSUB;
         4'd12:   op = OP_MSUBU;
`endif
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

   function automatic logic is_mul_op(input md_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
             (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_div_op(input md_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_sched_if.sv
// rtl/mult_div_sched_if.sv - EX-stage request and scheduler status signals of mult_div_sched.
interface mult_div_sched_if;
   logic [3:0]  md_op;
   logic        md_valid;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        busy;
   logic        stall;
   logic [31:0] hilo_out;

   modport master (
      output md_op, md_valid, rs_val, rt_val, flush,
      input  busy, stall, hilo_out
   );

   modport slave (
      input  md_op, md_valid, rs_val, rt_val, flush,
      output busy, stall, hilo_out
   );
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit product/quotient datapath for mult_div_sched.
// With MDU_MADD_EN the accumulate ops add/subtract the product to/from {HI,LO}.
module mdu_arith
   import mdu_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_MADD_EN
   input  logic [63:0] acc,
`endif
   output logic [63:0] result,
   output logic        div_zero
);

   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        udivisor;
   logic signed [32:0] sdividend;
   logic signed [32:0] sdivisor;
   logic               b_zero;

   always_comb begin
      b_zero    = (b == 32'd0);
      div_zero  = is_div_op(op) && b_zero;
      prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u    = {32'd0, a} * {32'd0, b};
      // A zero divisor is swapped for 1 so the datapath stays defined; the result is discarded.
      udivisor  = b_zero ? 32'd1 : b;
      // 33-bit signed divide keeps 0x80000000 / -1 from overflowing.
      sdividend = {a[31], a};
      sdivisor  = {udivisor[31], udivisor};
      result    = 64'd0;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV:   result = {32'(sdividend % sdivisor), 32'(sdividend / sdivisor)};
         OP_DIVU:  result = {a % udivisor, a / udivisor};
`ifdef MDU_MADD_EN
         OP_MADD:  result = acc + prod_s;
         OP_MADDU: result = acc + prod_u;
         OP_MSUB:  result = acc - prod_s;
         OP_MSUBU: result = acc - prod_u;
`endif
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mult_div_sched.sv
// rtl/mult_div_sched.sv - multi-cycle mult/div scheduler with HI/LO and pipeline stall control.
// Optional MDU_MADD_EN adds multiply-accumulate ops with the multiply latency.
module mult_div_sched
   import mdu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   mult_div_sched_if.slave   md
);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   md_op_e      op_q, op_d;
   md_op_e      op_in;
   logic [63:0] arith_result;
   logic        div_zero;
   logic        busy;

   mdu_arith u_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
`ifdef MDU_MADD_EN
      .acc      ({hi_q, lo_q}),
`endif
      .result   (arith_result),
      .div_zero (div_zero)
   );

   assign op_in       = decode_op(md.md_op);
   assign busy        = (state_q != IDLE);
   assign md.busy     = busy;
   assign md.stall    = md.md_valid && (op_in != OP_NONE) && busy;
   assign md.hilo_out = (op_in == OP_MFHI) ? hi_q :
                        (op_in == OP_MFLO) ? lo_q : 32'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= OP_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (md.md_valid && !md.flush) begin
               if (is_mul_op(op_in)) begin
                  op_d    = op_in;
                  a_d     = md.rs_val;
                  b_d     = md.rt_val;
                  cnt_d   = MUL_CNT_INIT;
                  state_d = MUL_RUN;
               end else if (is_div_op(op_in)) begin
                  op_d    = op_in;
                  a_d     = md.rs_val;
                  b_d     = md.rt_val;
                  cnt_d   = DIV_CNT_INIT;
                  state_d = DIV_RUN;
               end else if (op_in == OP_MTHI) begin
                  hi_d = md.rs_val;
               end else if (op_in == OP_MTLO) begin
                  lo_d = md.rs_val;
               end
            end
         end
         MUL_RUN, DIV_RUN: begin
            // Flush wins over the final write; md_op is ignored throughout.
            if (md.flush) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = IDLE;
               if (!div_zero) begin
                  {hi_d, lo_d} = arith_result;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

endmodule

// File: doc/mult_div_sched.md
MULT_DIV_SCHED -- requirements
Module: mult_div_sched

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port md_op  input  4  EX-stage mult/div op code; 0 = NONE (encodings in package).
REQ-004 SHALL have port md_valid  input  1  EX-stage instruction is valid and not being stalled by other hazards.
REQ-005 SHALL have port rs_val  input  32  forwarded rs operand.
REQ-006 SHALL have port rt_val  input  32  forwarded rt operand.
REQ-007 SHALL have port flush  input  1  kill the in-flight operation (exception/redirect).
REQ-008 SHALL have port busy  output  1  iterative operation in progress.
REQ-009 SHALL have port stall  output  1  freeze IF/ID/EX this cycle.
REQ-010 SHALL have port hilo_out  output  32  HI for MFHI, LO for MFLO, otherwise 0.

Function
REQ-011 SHALL decode ops: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; undefined codes behave as NONE.
REQ-012 SHALL run FSM states IDLE, MUL_RUN, DIV_RUN, plus a 4-bit down-counter cnt.
REQ-013 SHALL accept an op only when md_valid=1, state=IDLE and flush=0 (the accepting edge is t).
REQ-014 SHALL, on accepting MULT/MULTU, latch operands, load cnt=MUL_LAT-1 (MUL_LAT=5), enter MUL_RUN, and drive busy=1 for cycles t+1..t+5.
REQ-015 SHALL, on accepting DIV/DIVU, latch operands, load cnt=DIV_LAT-1 (DIV_LAT=10), enter DIV_RUN, and drive busy=1 for cycles t+1..t+10.
REQ-016 SHALL decrement cnt each RUN cycle, write HI/LO at the edge where cnt=0, return to IDLE, and make new HI/LO visible the cycle busy falls.
REQ-017 SHALL form products with 64-bit arithmetic: MULT signed, MULTU unsigned, {HI,LO}=product.
REQ-018 SHALL compute DIV as signed, truncated toward zero: LO=quotient, HI=remainder carrying the dividend's sign; DIVU unsigned.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0.
REQ-020 SHALL, on divide by zero, still take DIV_LAT cycles and leave HI/LO unchanged.
REQ-021 SHALL write rs_val to HI (MTHI) or LO (MTLO) at the accepting edge with no busy cycles.
REQ-022 SHALL drive hilo_out combinationally from current HI/LO; MFHI/MFLO are never stalled when busy=0.
REQ-023 SHALL set stall = md_valid & (md_op≠NONE) & busy; non-md instructions are never stalled.
REQ-024 SHALL, on flush=1 in any RUN state, go to IDLE at the next edge, drop busy, and leave HI/LO unchanged.
REQ-025 SHALL give flush priority over an accept in the same cycle, and over a cnt=0 write in the same cycle (no write occurs).
REQ-026 SHALL ignore md_op while busy=1; the held instruction is re-presented and accepted the cycle after busy falls.

Reset
REQ-027 SHALL, on reset=0, asynchronously force state=IDLE, cnt=0, HI=0, LO=0, busy=0, stall=0, hilo_out=0.
REQ-028 SHALL abandon any in-flight operation when reset asserts mid-operation, with no HI/LO write.

Configuration
REQ-029 SHALL, with MDU_MADD_EN defined, add ops 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU: {HI,LO}±=product, MUL_LAT latency, wrap modulo 2^64.
REQ-030 SHALL, without MDU_MADD_EN, treat codes 9-12 as NONE.

Structure
REQ-031 SHALL place op encodings, MUL_LAT, DIV_LAT and the FSM state type in shared package mdu_pkg.
REQ-032 SHALL isolate the 64-bit product/quotient arithmetic in one combinational sub-module mdu_arith; FSM, counter and HI/LO stay in mult_div_sched.

Verification
REQ-033 SHALL cover: MULT 0xFFFFFFFE × 3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-034 SHALL cover: DIV -7 / 2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover: MFLO presented on the cycle after a MULT is accepted -> stall=1 for 5 cycles, then hilo_out equals the new LO with stall=0.
REQ-036 SHALL cover: DIV 5 / 0 with HI=0x11, LO=0x22 -> 10 busy cycles, HI/LO unchanged.
REQ-037 SHALL cover: flush on the 3rd busy cycle of a MULT -> busy=0 next cycle, HI/LO unchanged; MTHI 0xABCD then MFHI -> hilo_out=0x0000ABCD with no stall.
REQ-038 SHALL cover: reset=0 asserted mid-DIV -> all outputs 0 immediately; with MDU_MADD_EN defined, MADD 2×3 onto HI=0, LO=4 -> LO=10 after 5 cycles.
